// File: rtl/qk_seq_pkg.sv
// Shared definitions for the instruction sequencer: inst word layout,
// command opcodes and FSM state encodings.
package qk_seq_pkg;

  localparam int INST_W = 26;
  localparam int ADDR_W = 4;

  // inst word bit positions
  localparam int INST_QSEL     = 25;
  localparam int INST_QWA_LSB  = 21;
  localparam int INST_QRA_LSB  = 17;
  localparam int INST_KA_LSB   = 13;
  localparam int INST_OFIFO_RD = 12;
  localparam int INST_PA_LSB   = 8;
  localparam int INST_EXECUTE  = 7;
  localparam int INST_LOAD     = 6;
  localparam int INST_QMEM_RD  = 5;
  localparam int INST_QMEM_WR  = 4;
  localparam int INST_KMEM_RD  = 3;
  localparam int INST_KMEM_WR  = 2;
  localparam int INST_PMEM_RD  = 1;
  localparam int INST_PMEM_WR  = 0;

  // cmd_op encodings
  localparam logic CMD_LOAD_K = 1'b0;
  localparam logic CMD_RUN    = 1'b1;

  typedef enum logic [2:0] {
    TOP_IDLE,
    TOP_KWR,
    TOP_KLD,
    TOP_RUN,
    TOP_FIN
  } top_state_t;

  typedef enum logic [1:0] {
    EX_IDLE,
    EX_EXEC,
    EX_GAP,
    EX_DRAIN
  } exec_state_t;

endpackage

// File: rtl/qk_exec_drain_fsm.sv
// Per-batch execute / gap / drain sequencer. A launch pulse in cycle s puts
// the first EXEC cycle in s+1; all outputs are registered and zero when idle.
module qk_exec_drain_fsm
  import qk_seq_pkg::*;
#(
  parameter int sram_depth = 16,
  parameter int drain_gap  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              launch,
  output logic              busy,
  output logic              batch_done,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              execute,
  output logic              qmem_rd,
  output logic              ofifo_rd,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic              pmem_wr
);

  localparam int CW = 8;
  localparam logic [CW-1:0] DEPTH_LAST = CW'(sram_depth - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(drain_gap - 1);

  exec_state_t   state_reg;
  logic [CW-1:0] cnt_reg;

  assign busy       = (state_reg != EX_IDLE);
  assign batch_done = (state_reg == EX_DRAIN) && (cnt_reg == DEPTH_LAST);

  // State walk plus outputs prepared for the cycle that follows each edge
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= EX_IDLE;
      cnt_reg   <= '0;
      rd_addr   <= '0;
      execute   <= 1'b0;
      qmem_rd   <= 1'b0;
      ofifo_rd  <= 1'b0;
      pmem_addr <= '0;
      pmem_wr   <= 1'b0;
    end else begin
      case (state_reg)
        EX_IDLE: begin
          if (launch) begin
            state_reg <= EX_EXEC;
            cnt_reg   <= '0;
            execute   <= 1'b1;
            qmem_rd   <= 1'b1;
            rd_addr   <= '0;
          end
        end
        EX_EXEC: begin
          if (cnt_reg == DEPTH_LAST) begin
            state_reg <= EX_GAP;
            cnt_reg   <= '0;
            execute   <= 1'b0;
            qmem_rd   <= 1'b0;
            rd_addr   <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
            rd_addr <= ADDR_W'(cnt_reg + 1'b1);
          end
        end
        EX_GAP: begin
          if (cnt_reg == GAP_LAST) begin
            state_reg <= EX_DRAIN;
            cnt_reg   <= '0;
            ofifo_rd  <= 1'b1;
            pmem_wr   <= 1'b1;
            pmem_addr <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        EX_DRAIN: begin
          if (cnt_reg == DEPTH_LAST) begin
            state_reg <= EX_IDLE;
            cnt_reg   <= '0;
            ofifo_rd  <= 1'b0;
            pmem_wr   <= 1'b0;
            pmem_addr <= '0;
          end else begin
            cnt_reg   <= cnt_reg + 1'b1;
            pmem_addr <= ADDR_W'(cnt_reg + 1'b1);
          end
        end
        default: state_reg <= EX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/qk_inst_sequencer.sv
// Drives fullchip's inst word and mem_in bus: loads K rows into kmem and the
// PE array, then streams Q batches through the double-buffered qmem while the
// exec/drain sub-FSM processes the previous batch.
module qk_inst_sequencer
  import qk_seq_pkg::*;
#(
  parameter int bw         = 4,
  parameter int pr         = 8,
  parameter int col        = 8,
  parameter int sram_depth = 16,
  parameter int drain_gap  = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_op,
  input  logic [7:0]         cmd_nbatch,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [pr*bw-1:0]   in_data,
  output logic [pr*bw-1:0]   mem_in,
  output logic [INST_W-1:0]  inst,
  output logic               done,
  output logic               err,
  output logic               k_loaded
);

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] K_LAST    = CNT_W'(col - 1);
  localparam logic [CNT_W-1:0] KLD_END   = CNT_W'(col + 3);
  localparam logic [CNT_W-1:0] KRD_LAST  = CNT_W'(col + 1);
  localparam logic [ADDR_W-1:0] Q_LAST   = ADDR_W'(sram_depth - 1);

  top_state_t        state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [ADDR_W-1:0] qrow_reg;
  logic [7:0]        nbatch_reg;
  logic [7:0]        wr_batches_reg;
  logic [7:0]        drained_reg;
  logic              wsel_reg;
  logic              wfull_reg;
  logic              kmem_wr_reg;
  logic              kmem_rd_reg;
  logic              load_reg;
  logic              qmem_wr_reg;
  logic [ADDR_W-1:0] kaddr_reg;
  logic [ADDR_W-1:0] qwaddr_reg;

  logic              row_fire;
  logic              launch;
  logic              ex_busy;
  logic              ex_batch_done;
  logic [ADDR_W-1:0] ex_rd_addr;
  logic              ex_execute;
  logic              ex_qmem_rd;
  logic              ex_ofifo_rd;
  logic [ADDR_W-1:0] ex_pmem_addr;
  logic              ex_pmem_wr;
  logic              krd_window;

  assign cmd_ready  = (state_reg == TOP_IDLE) && !reset;
  assign in_ready   = !reset && ((state_reg == TOP_KWR) ||
                      ((state_reg == TOP_RUN) && !wfull_reg && (wr_batches_reg != nbatch_reg)));
  assign row_fire   = in_valid && in_ready;
  // Buffer swap: a full write buffer is handed to an idle exec FSM
  assign launch     = (state_reg == TOP_RUN) && wfull_reg && !ex_busy;
  assign krd_window = (cnt_reg >= CNT_W'(2)) && (cnt_reg <= KRD_LAST);

  qk_exec_drain_fsm #(
    .sram_depth (sram_depth),
    .drain_gap  (drain_gap)
  ) u_exec (
    .clk        (clk),
    .reset      (reset),
    .launch     (launch),
    .busy       (ex_busy),
    .batch_done (ex_batch_done),
    .rd_addr    (ex_rd_addr),
    .execute    (ex_execute),
    .qmem_rd    (ex_qmem_rd),
    .ofifo_rd   (ex_ofifo_rd),
    .pmem_addr  (ex_pmem_addr),
    .pmem_wr    (ex_pmem_wr)
  );

  // Command FSM: K write/load, Q batch writer, buffer swap and completion
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= TOP_IDLE;
      cnt_reg        <= '0;
      qrow_reg       <= '0;
      nbatch_reg     <= '0;
      wr_batches_reg <= '0;
      drained_reg    <= '0;
      wsel_reg       <= 1'b0;
      wfull_reg      <= 1'b0;
      kmem_wr_reg    <= 1'b0;
      kmem_rd_reg    <= 1'b0;
      load_reg       <= 1'b0;
      qmem_wr_reg    <= 1'b0;
      kaddr_reg      <= '0;
      qwaddr_reg     <= '0;
      mem_in         <= '0;
      done           <= 1'b0;
      err            <= 1'b0;
      k_loaded       <= 1'b0;
    end else begin
      // write strobes and addresses are valid only in the cycle after a row is taken
      done        <= 1'b0;
      err         <= 1'b0;
      kmem_wr_reg <= 1'b0;
      qmem_wr_reg <= 1'b0;
      kaddr_reg   <= '0;
      qwaddr_reg  <= '0;
      case (state_reg)
        TOP_IDLE: begin
          if (cmd_valid) begin
            if (cmd_op == CMD_LOAD_K) begin
              state_reg <= TOP_KWR;
              cnt_reg   <= '0;
            end else if (!k_loaded) begin
              done      <= 1'b1;
              err       <= 1'b1;
              state_reg <= TOP_FIN;
            end else if (cmd_nbatch == 8'd0) begin
              done      <= 1'b1;
              state_reg <= TOP_FIN;
            end else begin
              state_reg      <= TOP_RUN;
              nbatch_reg     <= cmd_nbatch;
              wr_batches_reg <= '0;
              drained_reg    <= '0;
              qrow_reg       <= '0;
              wfull_reg      <= 1'b0;
            end
          end
        end
        TOP_KWR: begin
          if (row_fire) begin
            kmem_wr_reg <= 1'b1;
            kaddr_reg   <= ADDR_W'(cnt_reg);
            mem_in      <= in_data;
            if (cnt_reg == K_LAST) begin
              state_reg <= TOP_KLD;
              cnt_reg   <= '0;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        TOP_KLD: begin
          // cnt_reg names the KLD cycle being prepared for the next clock
          if (cnt_reg == KLD_END) begin
            load_reg    <= 1'b0;
            kmem_rd_reg <= 1'b0;
            k_loaded    <= 1'b1;
            done        <= 1'b1;
            cnt_reg     <= '0;
            state_reg   <= TOP_IDLE;
          end else begin
            load_reg    <= 1'b1;
            kmem_rd_reg <= krd_window;
            kaddr_reg   <= krd_window ? ADDR_W'(cnt_reg - CNT_W'(2)) : '0;
            cnt_reg     <= cnt_reg + 1'b1;
          end
        end
        TOP_RUN: begin
          if (row_fire) begin
            qmem_wr_reg <= 1'b1;
            qwaddr_reg  <= qrow_reg;
            mem_in      <= in_data;
            if (qrow_reg == Q_LAST) begin
              qrow_reg       <= '0;
              wfull_reg      <= 1'b1;
              wr_batches_reg <= wr_batches_reg + 1'b1;
            end else begin
              qrow_reg <= qrow_reg + 1'b1;
            end
          end
          if (launch) begin
            wsel_reg  <= ~wsel_reg;
            wfull_reg <= 1'b0;
          end
          if (ex_batch_done) begin
            drained_reg <= drained_reg + 1'b1;
            if (drained_reg == nbatch_reg - 8'd1) begin
              done      <= 1'b1;
              state_reg <= TOP_IDLE;
            end
          end
        end
        TOP_FIN: state_reg <= TOP_IDLE;
        default: state_reg <= TOP_IDLE;
      endcase
    end
  end

  // Pack the registered fields into the instruction word
  always_comb begin
    inst                            = '0;
    inst[INST_QSEL]                 = ~wsel_reg;
    inst[INST_QWA_LSB +: ADDR_W]    = qwaddr_reg;
    inst[INST_QRA_LSB +: ADDR_W]    = ex_rd_addr;
    inst[INST_KA_LSB +: ADDR_W]     = kaddr_reg;
    inst[INST_OFIFO_RD]             = ex_ofifo_rd;
    inst[INST_PA_LSB +: ADDR_W]     = ex_pmem_addr;
    inst[INST_EXECUTE]              = ex_execute;
    inst[INST_LOAD]                 = load_reg;
    inst[INST_QMEM_RD]              = ex_qmem_rd;
    inst[INST_QMEM_WR]              = qmem_wr_reg;
    inst[INST_KMEM_RD]              = kmem_rd_reg;
    inst[INST_KMEM_WR]              = kmem_wr_reg;
    inst[INST_PMEM_RD]              = 1'b0;
    inst[INST_PMEM_WR]              = ex_pmem_wr;
  end

endmodule

// File: tb/tb_qk_inst_sequencer.sv
// Directed bench for qk_inst_sequencer: each command is run against a
// hand-built per-cycle table of expected inst words and handshake levels.
module tb_qk_inst_sequencer;

  localparam int NMAX = 128;
  localparam logic [31:0] KBASE  = 32'h1234_5678;
  localparam logic [31:0] QBASE  = 32'hCAFE_0000;
  localparam logic [31:0] QBASE2 = 32'h0BAD_F00D;
  localparam logic [31:0] QBASE3 = 32'h7777_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_op = 1'b0;
  logic [7:0]  cmd_nbatch = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'd0;
  logic [31:0] mem_in;
  logic [25:0] inst;
  logic        done;
  logic        err;
  logic        k_loaded;

  always #5 clk = ~clk;

  qk_inst_sequencer #(
    .bw(4), .pr(8), .col(8), .sram_depth(16), .drain_gap(10)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_nbatch (cmd_nbatch),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .mem_in     (mem_in),
    .inst       (inst),
    .done       (done),
    .err        (err),
    .k_loaded   (k_loaded)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // expected per-cycle tables, cycle 1 = first cycle after command acceptance
  logic [25:0] e_inst [NMAX];
  logic [31:0] e_mem  [NMAX];
  bit          e_done [NMAX];
  bit          e_rdy  [NMAX];
  bit          e_kl   [NMAX];
  bit          e_mv   [NMAX];

  function automatic logic [31:0] row_data(input int g, input logic [31:0] base);
    logic [7:0] b;
    b = 8'(g);
    return base ^ {b, ~b, b + 8'h3C, 8'hA5};
  endfunction

  task automatic clear_sched(input logic [25:0] base, input bit kl);
    for (int k = 0; k < NMAX; k++) begin
      e_inst[k] = base;
      e_mem[k]  = '0;
      e_done[k] = 1'b0;
      e_rdy[k]  = 1'b0;
      e_kl[k]   = kl;
      e_mv[k]   = 1'b0;
    end
  endtask

  task automatic set_field(input int k, input int lsb, input int w, input int val);
    logic [25:0] v;
    v = 26'(val) & ((26'd1 << w) - 26'd1);
    e_inst[k] = e_inst[k] | (v << lsb);
  endtask

  // one Q batch: 16 writes from wr_first spaced wr_step, EXEC from ex_first,
  // DRAIN 16+10 cycles after EXEC start
  task automatic sched_batch(input int wr_first, input int wr_step, input int ex_first,
                             input int g0, input logic [31:0] dbase);
    int k;
    for (int i = 0; i < 16; i++) begin
      k = wr_first + i * wr_step;
      set_field(k, 4, 1, 1);
      set_field(k, 21, 4, i);
      e_mv[k]  = 1'b1;
      e_mem[k] = row_data(g0 + i, dbase);
      k = ex_first + i;
      set_field(k, 7, 1, 1);
      set_field(k, 5, 1, 1);
      set_field(k, 17, 4, i);
      k = ex_first + 26 + i;
      set_field(k, 12, 1, 1);
      set_field(k, 0, 1, 1);
      set_field(k, 8, 4, i);
    end
  endtask

  task automatic run_sched(input logic op, input int nb, input int ncyc, input bit toggle,
                           input int total, input logic [31:0] dbase);
    int  g;
    bit  acc;
    @(negedge clk);
    chk("cmd_ready_before_cmd", cmd_ready, 1);
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_nbatch = 8'(nb);
    g   = 0;
    acc = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      chk($sformatf("inst@%0d", k), inst, e_inst[k]);
      chk($sformatf("done@%0d", k), done, e_done[k]);
      chk($sformatf("err@%0d", k), err, 0);
      chk($sformatf("in_ready@%0d", k), in_ready, e_rdy[k]);
      chk($sformatf("k_loaded@%0d", k), k_loaded, e_kl[k]);
      chk($sformatf("cmd_ready@%0d", k), cmd_ready, e_done[k]);
      if (e_mv[k]) chk($sformatf("mem_in@%0d", k), mem_in, e_mem[k]);
      if (acc) g++;
      in_valid = (g < total) && (!toggle || (k % 2 == 1));
      in_data  = row_data(g, dbase);
      acc      = in_valid && in_ready;
    end
    in_valid = 1'b0;
    $display("txn op=%0d nbatch=%0d toggle=%0d cycles=%0d rows_sent=%0d", op, nb, toggle, ncyc, g);
  endtask

  initial begin
    // reset values
    repeat (3) @(negedge clk);
    chk("rst_inst", inst, 26'h2000000);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_k_loaded", k_loaded, 0);
    chk("rst_mem_in", mem_in, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rel_cmd_ready", cmd_ready, 1);
    chk("rel_inst", inst, 26'h2000000);

    // RUN while K not loaded
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_nbatch = 8'd3;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("nok_done", done, 1);
    chk("nok_err", err, 1);
    chk("nok_cmd_ready", cmd_ready, 0);
    chk("nok_inst", inst, 26'h2000000);
    @(negedge clk);
    chk("nok_done_clr", done, 0);
    chk("nok_err_clr", err, 0);
    chk("nok_cmd_ready_back", cmd_ready, 1);
    chk("nok_inst2", inst, 26'h2000000);
    $display("txn RUN without K: done/err pulse observed");

    // LOAD_K: writes cycles 2..9, KLD cycles 10..20, done at 21
    clear_sched(26'h2000000, 1'b0);
    for (int k = 2; k <= 9; k++) begin
      set_field(k, 2, 1, 1);
      set_field(k, 13, 4, k - 2);
      e_mv[k]  = 1'b1;
      e_mem[k] = row_data(k - 2, KBASE);
    end
    for (int k = 10; k <= 20; k++) begin
      set_field(k, 6, 1, 1);
      if (k - 10 >= 2 && k - 10 <= 9) begin
        set_field(k, 3, 1, 1);
        set_field(k, 13, 4, k - 12);
      end
    end
    for (int k = 1; k <= 8; k++) e_rdy[k] = 1'b1;
    e_done[21] = 1'b1;
    e_kl[21]   = 1'b1;
    run_sched(1'b0, 0, 21, 1'b0, 8, KBASE);

    // RUN nbatch=2 back-to-back: swaps at cycles 18 and 61, done at 103
    clear_sched(26'h2000000, 1'b1);
    sched_batch(2, 1, 18, 0, QBASE);
    sched_batch(19, 1, 61, 16, QBASE);
    for (int k = 18; k <= 60; k++) e_inst[k][25] = 1'b0;
    for (int k = 1; k <= 16; k++) e_rdy[k] = 1'b1;
    for (int k = 18; k <= 33; k++) e_rdy[k] = 1'b1;
    e_done[103] = 1'b1;
    run_sched(1'b1, 2, 103, 1'b0, 32, QBASE);

    // RUN nbatch=1 with rows every other cycle: writes 2,4..32, EXEC from 33
    clear_sched(26'h2000000, 1'b1);
    sched_batch(2, 2, 33, 0, QBASE2);
    for (int k = 33; k <= 75; k++) e_inst[k][25] = 1'b0;
    for (int k = 1; k <= 31; k++) e_rdy[k] = 1'b1;
    e_done[75] = 1'b1;
    run_sched(1'b1, 1, 75, 1'b1, 16, QBASE2);

    // RUN nbatch=0 with K loaded: done without err, buffer select now 0
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_nbatch = 8'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("nb0_done", done, 1);
    chk("nb0_err", err, 0);
    chk("nb0_inst", inst, 26'h0);
    chk("nb0_k_loaded", k_loaded, 1);
    @(negedge clk);
    chk("nb0_done_clr", done, 0);
    chk("nb0_cmd_ready", cmd_ready, 1);
    $display("txn RUN nbatch=0: done pulse observed");

    // RUN nbatch=1 back-to-back, then reset in the middle of DRAIN (cycle 50)
    clear_sched(26'h0, 1'b1);
    sched_batch(2, 1, 18, 0, QBASE3);
    for (int k = 18; k <= 50; k++) e_inst[k][25] = 1'b1;
    for (int k = 1; k <= 16; k++) e_rdy[k] = 1'b1;
    run_sched(1'b1, 1, 50, 1'b0, 16, QBASE3);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_inst", inst, 26'h2000000);
    chk("mid_rst_k_loaded", k_loaded, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("post_rst_done@%0d", k), done, 0);
      chk($sformatf("post_rst_inst@%0d", k), inst, 26'h2000000);
      chk($sformatf("post_rst_cmd_ready@%0d", k), cmd_ready, 1);
    end
    $display("txn reset during DRAIN: state cleared");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/qk_inst_sequencer.md
# qk_inst_sequencer

Instruction sequencer that drives the 26-bit `inst` word and `mem_in` bus of `fullchip`, replacing hand-timed stimulus. It loads K rows into kmem and the PE array, then streams Q batches through the double-buffered qmem, executes, and drains the ofifo into pmem, overlapping batch N+1 qmem writes with batch N execute/drain. It sits between a host command/row stream and `fullchip`.

## Interface
- `bw`, 4: bits per Q/K element
- `pr`, 8: elements per row
- `col`, 8: K rows (PE columns)
- `sram_depth`, 16: Q rows per batch (≤16, 4-bit addresses)
- `drain_gap`, 10: idle cycles between end of execute and ofifo drain
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `cmd_valid`  in  1  command request
- `cmd_ready`  out  1  high only in IDLE
- `cmd_op`  in  1  0 = LOAD_K, 1 = RUN
- `cmd_nbatch`  in  8  Q batch count for RUN
- `in_valid`  in  1  row valid
- `in_ready`  out  1  row accepted when `in_valid & in_ready`
- `in_data`  in  pr*bw  one K or Q row, element j at `[bw*j +: bw]`
- `mem_in`  out  pr*bw  registered row to `fullchip`
- `inst`  out  26  registered instruction word to `fullchip`
- `done`  out  1  one-cycle pulse at command completion
- `err`  out  1  one-cycle pulse with `done` for RUN issued while K not loaded
- `k_loaded`  out  1  level, set after LOAD_K completes

## Operation
- `inst` fields: [25] qmem read-buffer sel, [24:21] qmem wr addr, [20:17] qmem rd addr, [16:13] kmem addr, [12] ofifo_rd, [11:8] pmem addr, [7] execute, [6] load, [5] qmem_rd, [4] qmem_wr, [3] kmem_rd, [2] kmem_wr, [1] pmem_rd (always 0), [0] pmem_wr.
- Buffer select: register `wsel` (reset 0) is the write buffer; `inst[25] = ~wsel` always. Swap toggles `wsel`.
- Top FSM: IDLE → KWR → KLD → IDLE for LOAD_K; IDLE → RUN → IDLE for RUN.
- KWR: accept `col` rows; row r → `kmem_wr`=1, kmem addr=r, `mem_in`=row. Stall cycles (no row): `kmem_wr`=0.
- KLD: `col`+3 cycles, `load`=1 throughout; cycles 2..col+1 `kmem_rd`=1, kmem addr = cycle−2; cycles 0,1,col+2 `kmem_rd`=0, addr 0. Then `k_loaded`=1, `done`.
- RUN writer: accepts Q rows into buffer `wsel`, `qmem_wr`=1, wr addr = row index in batch 0..sram_depth−1. After a full batch sets `wfull`; `in_ready`=0 while `wfull` or all `cmd_nbatch` batches written.
- Swap: when `wfull` and exec FSM IDLE: toggle `wsel`, clear `wfull`, launch exec.
- Exec FSM (sub-module): IDLE → EXEC (sram_depth cycles, `execute`=`qmem_rd`=1, rd addr 0..sram_depth−1) → GAP (`drain_gap` cycles, all zero) → DRAIN (sram_depth cycles, `ofifo_rd`=`pmem_wr`=1, pmem addr 0..sram_depth−1) → IDLE. Each batch overwrites pmem 0..sram_depth−1.
- RUN completes when `cmd_nbatch` batches drained; `done` pulses; `k_loaded` stays set.
- RUN with `k_loaded`=0: accepted, no `inst` activity, `done`+`err` next cycle. RUN with `cmd_nbatch`=0: `done` next cycle, no `err`.

## Timing
- Reset values: `inst`=26'h2000000 (only bit 25 set), `mem_in`=0, `cmd_ready`=0 during reset then 1, `in_ready`=0, `done`=`err`=`k_loaded`=0, `wsel`=0, all FSMs IDLE.
- Command accepted at edge t → `cmd_ready`=0 from t+1.
- Row accepted at edge t → corresponding write bits, address and `mem_in` valid in cycle t+1 only.
- KLD starts the cycle after the last K row's write cycle.
- Swap decided at edge s → `inst[25]` new value and first EXEC cycle (rd addr 0) in cycle s+1.
- Batch latency from swap: EXEC starts s+1, DRAIN first cycle s+1+sram_depth+drain_gap, `done` one cycle after last DRAIN cycle of final batch.
- Writing of batch n+1 overlaps EXEC/GAP/DRAIN of batch n; `qmem_wr` and `qmem_rd` may be high in the same cycle (different buffers).
- `reset` mid-operation: all state returns to reset values in the next cycle; `k_loaded` cleared.

## Structure
- Package `qk_seq_pkg`: `inst` bit-position/field localparams, `cmd_op` encodings, top and exec FSM state enums.
- Sub-module `qk_exec_drain_fsm`: exec FSM with launch input and busy/batch_done outputs, driving bits 20:17, 12, 11:8, 7, 5, 0.

## Test plan
- Reset → `inst`=26'h2000000, `cmd_ready`=1 after reset release, `in_ready`=0.
- LOAD_K, 8 back-to-back rows → kmem_wr with addr 0..7 for 8 cycles; then 11 cycles `load`=1 with `kmem_rd` at cycles 2..9, addr 0..7; `done`, `k_loaded`=1.
- RUN nbatch=2, rows back-to-back → `inst[25]` 1→0 after batch0, →1 after batch1; batch1 writes overlap batch0 EXEC; two 16-cycle DRAINs with pmem addr 0..15; single `done`.
- RUN nbatch=1 with `in_valid` toggling every other cycle → qmem wr addr still 0..15 contiguous on write cycles, execute starts cycle after 16th row write.
- RUN before LOAD_K → `done`+`err` one cycle after acceptance, `inst` unchanged; RUN nbatch=0 after LOAD_K → `done`, no `err`.
- `reset` asserted mid-DRAIN → next cycle `inst`=26'h2000000, `k_loaded`=0, no `done`.
